input_debouncer: RTL and testbench
==================================

// Module: input_debouncer
//
// PURPOSE
//  Input conditioning stage that feeds the two-input gate.
//  Takes raw asynchronous inputs (switches/pins) and passes each through a 2-flop synchronizer and a counter debouncer.
//  Drives clean levels (clean[0] -> A, clean[1] -> B) plus one-cycle edge pulses.
//  Goal: the gate only sees settled, glitch-free, clock-aligned inputs.
//
// PARAMETERS
//  WIDTH          2   number of independent input channels
//  STABLE_CYCLES  4   consecutive disagreeing cycles before clean flips; legal range 1..255
//  CNT_W          $clog2(STABLE_CYCLES+1)   localparam, per-channel counter width (not overridable)
//
// PORTS
//  clk      in   1      single system clock, rising edge
//  rst_n    in   1      asynchronous, active-low reset
//  raw      in   WIDTH  unsynchronized raw inputs
//  clean    out  WIDTH  debounced level; bit0 drives gate A, bit1 drives gate B
//  rise     out  WIDTH  1-cycle pulse, same edge clean goes 0->1
//  fall     out  WIDTH  1-cycle pulse, same edge clean goes 1->0
//  changed  out  1      |(rise|fall), registered alongside them
//
// BEHAVIOUR
//  - Reset (rst_n=0, async):
//    - sync flops, counters, clean, rise, fall and changed all clear to 0 immediately.
//    - Release is synchronous to clk via normal flop behaviour.
//  - Synchronizer: s1<=raw[i]; s2<=s1. s2 is the only value the debounce logic reads.
//  - Per-channel FSM, 4 states:
//    - STABLE_LO: clean=0, cnt=0
//    - PEND_HI: clean=0, cnt>0
//    - STABLE_HI: clean=1, cnt=0
//    - PEND_LO: clean=1, cnt>0
//  - Transitions, evaluated at each clk edge:
//    - s2==clean: cnt<=0. PEND_x returns to STABLE_x (glitch rejected, no pulse).
//    - s2!=clean and cnt<STABLE_CYCLES-1: cnt<=cnt+1.
//    - s2!=clean and cnt==STABLE_CYCLES-1: clean<=s2, cnt<=0, assert rise or fall for exactly 1 cycle.
//  - Latency: raw settles before edge e1. clean updates at edge e(STABLE_CYCLES+2).
//    - STABLE_CYCLES=4 gives 6 edges.
//  - STABLE_CYCLES=1: clean follows s2 one edge later, so 3-edge total latency. Counter never increments.
//  - Counter never exceeds STABLE_CYCLES-1. No wrap-around possible.
//  - rise/fall/changed are registered. They deassert on the following edge unless the channel flips again.
//    - Minimum spacing between flips is STABLE_CYCLES cycles, so pulses never merge.
//  - Channels are fully independent. Simultaneous flips on several channels:
//    - each raises its own rise/fall bit;
//    - changed is a single 1-cycle pulse.
//  - raw held high through reset: after release it is treated as a 0->1 change.
//    - clean goes high at edge STABLE_CYCLES+2 and emits a rise pulse.
//  - Reset asserted mid-count: count is aborted, clean returns to 0, no pulse is emitted.
//  - No combinational path from raw to any output.
//
// STRUCTURE
//  - Shared include debounce_defs.vh holds:
//    - state encodings ST_STABLE_LO / ST_PEND_HI / ST_STABLE_HI / ST_PEND_LO (2 bits);
//    - default STABLE_CYCLES.
//  - Sub-module debounce_channel(clk, rst_n, raw_bit, clean, rise, fall):
//    - one synchronizer, one FSM and one counter.
//    - Top generates WIDTH instances and ORs the pulses into changed.
//  - Top is a generate loop plus the changed register only.
//
// TESTING (WIDTH=2, STABLE_CYCLES=4)
//  1. Reset: rst_n=0 with raw=2'b11, then release.
//     -> all outputs 0 during reset.
//     -> clean=2'b11 at edge 6 after release.
//     -> rise=2'b11 and changed=1 for 1 cycle.
//  2. Clean step: raw[0] 0->1 held.
//     -> clean[0]=1 exactly 6 edges later.
//     -> rise[0] 1-cycle pulse; fall=0; clean[1] unchanged.
//  3. Glitch: raw[1] high for 3 cycles, then low.
//     -> clean[1] stays 0; rise/fall/changed never assert.
//     -> repeat with 4-cycle high: clean[1] toggles.
//  4. Bounce: raw[0] toggles every cycle for 20 cycles, then settles at 0 from clean=1.
//     -> exactly one fall[0] pulse, 6 edges after settling.
//  5. Reset mid-count: raw[0] rises, rst_n pulsed low at edge 3.
//     -> clean=0 immediately, no pulse.
//     -> after release, clean[0]=1 at edge 6.
//  6. Simultaneous: raw 2'b00->2'b11 on the same edge.
//     -> rise=2'b11 on the same cycle, changed single 1-cycle pulse.

Source files
------------

// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the input debouncer: per-channel state encodings and
// the default settle time.
package input_debouncer_pkg;

  localparam int DEFAULT_STABLE_CYCLES = 4;

  // Bit 1 of the encoding is the clean level; bit 0 marks a pending change.
  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'b00,
    ST_PEND_HI   = 2'b01,
    ST_STABLE_HI = 2'b10,
    ST_PEND_LO   = 2'b11
  } db_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchronizer, settle counter and four-state FSM.
// flip_next announces a flip one edge early so the top can register changed in step.
module debounce_channel
  import input_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_bit,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic flip_next
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  db_state_e        state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw_bit;
      s2 <= s1;
    end
  end

  assign clean     = (state == ST_STABLE_HI) || (state == ST_PEND_LO);
  assign flip_next = (s2 != clean) && (cnt == CNT_LAST);

  // Any cycle where s2 agrees with clean discards the partial count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_STABLE_LO;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 == clean) begin
        cnt   <= '0;
        state <= clean ? ST_STABLE_HI : ST_STABLE_LO;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        state <= s2 ? ST_STABLE_HI : ST_STABLE_LO;
        rise  <= s2;
        fall  <= ~s2;
      end else begin
        cnt   <= cnt + CNT_W'(1);
        state <= clean ? ST_PEND_LO : ST_PEND_HI;
      end
    end
  end

endmodule

// File: rtl/input_debouncer.sv
// Debounces WIDTH raw inputs into clean levels for the two-input gate,
// with per-channel edge pulses and a combined changed pulse.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int WIDTH         = 2,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] clean,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  logic [WIDTH-1:0] flip_next;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_bit  (raw[g]),
      .clean    (clean[g]),
      .rise     (rise[g]),
      .fall     (fall[g]),
      .flip_next(flip_next[g])
    );
  end

  // Built from the channels' look-ahead so it lands on the same edge as rise/fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) changed <= 1'b0;
    else        changed <= |flip_next;
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer (WIDTH=2, STABLE_CYCLES=4) using a
// cycle-stamped expectation queue drained after every clock edge.
module tb_input_debouncer;

  logic       clk;
  logic       rst_n;
  logic [1:0] raw;
  logic [1:0] clean;
  logic [1:0] rise;
  logic [1:0] fall;
  logic       changed;

  typedef struct {
    int         when;
    logic [1:0] clean;
    logic [1:0] rise;
    logic [1:0] fall;
    logic       changed;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cycle;
  int   checks;
  int   errors;

  input_debouncer #(
    .WIDTH(2),
    .STABLE_CYCLES(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (raw),
    .clean  (clean),
    .rise   (rise),
    .fall   (fall),
    .changed(changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [1:0] v);
    raw = v;
  endtask

  task automatic pushExpect(input int dt, input logic [1:0] c, input logic [1:0] r,
                            input logic [1:0] f, input logic ch, input string tag);
    exp_t e;
    int   i;
    e.when    = cycle + dt;
    e.clean   = c;
    e.rise    = r;
    e.fall    = f;
    e.changed = ch;
    e.tag     = tag;
    i = 0;
    while (i < sb.size() && sb[i].when <= e.when) i++;
    sb.insert(i, e);
  endtask

  task automatic checkOutput();
    exp_t e;
    while (sb.size() > 0 && sb[0].when <= cycle) begin
      e = sb.pop_front();
      checks++;
      assert (clean === e.clean) else begin
        errors++;
        $error("[TB] FAIL %s@%0d clean observed=%b expected=%b", e.tag, cycle, clean, e.clean);
      end
      checks++;
      assert (rise === e.rise) else begin
        errors++;
        $error("[TB] FAIL %s@%0d rise observed=%b expected=%b", e.tag, cycle, rise, e.rise);
      end
      checks++;
      assert (fall === e.fall) else begin
        errors++;
        $error("[TB] FAIL %s@%0d fall observed=%b expected=%b", e.tag, cycle, fall, e.fall);
      end
      checks++;
      assert (changed === e.changed) else begin
        errors++;
        $error("[TB] FAIL %s@%0d changed observed=%b expected=%b", e.tag, cycle, changed, e.changed);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    checkOutput();
  endtask

  task automatic expectNow(input logic [1:0] c, input string tag);
    pushExpect(0, c, 2'b00, 2'b00, 1'b0, tag);
    checkOutput();
  endtask

  // Flip seen 6 edges after the drive; quiet one edge before and after.
  task automatic expectFlip(input logic [1:0] old_c, input logic [1:0] new_c,
                            input logic [1:0] r, input logic [1:0] f, input string tag);
    pushExpect(5, old_c, 2'b00, 2'b00, 1'b0, {tag, "_pre"});
    pushExpect(6, new_c, r, f, 1'b1, {tag, "_edge"});
    pushExpect(7, new_c, 2'b00, 2'b00, 1'b0, {tag, "_post"});
  endtask

  initial begin
    cycle  = 0;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    applyStimulus(2'b11);
    #1;
    expectNow(2'b00, "reset_t0");
    tick();
    tick();
    expectNow(2'b00, "reset_hold");

    $display("[TB] step 1: release with raw high");
    rst_n = 1'b1;
    expectFlip(2'b00, 2'b11, 2'b11, 2'b00, "rel_rise");
    repeat (8) tick();

    $display("[TB] both channels low again");
    applyStimulus(2'b00);
    expectFlip(2'b11, 2'b00, 2'b00, 2'b11, "both_fall");
    repeat (8) tick();

    $display("[TB] step 2: clean step on raw[0]");
    applyStimulus(2'b01);
    expectFlip(2'b00, 2'b01, 2'b01, 2'b00, "step0");
    repeat (8) tick();

    $display("[TB] step 3: 3-cycle glitch on raw[1]");
    applyStimulus(2'b11);
    for (int d = 1; d <= 10; d++) pushExpect(d, 2'b01, 2'b00, 2'b00, 1'b0, "glitch3");
    repeat (3) tick();
    applyStimulus(2'b01);
    repeat (7) tick();

    $display("[TB] step 3b: 4-cycle pulse on raw[1]");
    applyStimulus(2'b11);
    expectFlip(2'b01, 2'b11, 2'b10, 2'b00, "pulse4_up");
    pushExpect(9,  2'b11, 2'b00, 2'b00, 1'b0, "pulse4_hold");
    pushExpect(10, 2'b01, 2'b00, 2'b10, 1'b1, "pulse4_down");
    pushExpect(11, 2'b01, 2'b00, 2'b00, 1'b0, "pulse4_quiet");
    repeat (4) tick();
    applyStimulus(2'b01);
    repeat (8) tick();

    $display("[TB] step 4: bounce on raw[0]");
    for (int d = 1; d <= 25; d++) pushExpect(d, 2'b01, 2'b00, 2'b00, 1'b0, "bounce");
    pushExpect(26, 2'b00, 2'b00, 2'b01, 1'b1, "bounce_fall");
    for (int d = 27; d <= 30; d++) pushExpect(d, 2'b00, 2'b00, 2'b00, 1'b0, "bounce_after");
    for (int i = 0; i < 20; i++) begin
      applyStimulus({1'b0, i[0]});
      tick();
    end
    applyStimulus(2'b00);
    repeat (10) tick();

    $display("[TB] step 5: reset mid-count");
    applyStimulus(2'b01);
    for (int d = 1; d <= 3; d++) pushExpect(d, 2'b00, 2'b00, 2'b00, 1'b0, "midcnt_pre");
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    expectNow(2'b00, "midcnt_rst");
    tick();
    expectNow(2'b00, "midcnt_rst_edge");
    rst_n = 1'b1;
    for (int d = 1; d <= 5; d++) pushExpect(d, 2'b00, 2'b00, 2'b00, 1'b0, "midcnt_wait");
    pushExpect(6, 2'b01, 2'b01, 2'b00, 1'b1, "midcnt_rise");
    pushExpect(7, 2'b01, 2'b00, 2'b00, 1'b0, "midcnt_post");
    repeat (8) tick();

    $display("[TB] step 5b: async clear of a high level");
    applyStimulus(2'b00);
    rst_n = 1'b0;
    #1;
    expectNow(2'b00, "async_clear");
    tick();
    rst_n = 1'b1;
    for (int d = 1; d <= 8; d++) pushExpect(d, 2'b00, 2'b00, 2'b00, 1'b0, "after_clear");
    repeat (8) tick();

    $display("[TB] step 6: simultaneous rise");
    applyStimulus(2'b11);
    expectFlip(2'b00, 2'b11, 2'b11, 2'b00, "simul");
    repeat (8) tick();

    for (int i = 0; i < 30 && sb.size() > 0; i++) tick();
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("[TB] FAIL drain pending observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
